// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - registered-FIFO read drainer presenting a framed valid/ready stream
//
// Purpose:
//   Pulls words out of a FIFO whose read data appears one cycle after an
//   accepted read. Words land in a two-entry buffer (head + skid) that drives
//   a valid/ready stream. The FIFO's read latency is hidden from downstream
//   backpressure, and the stream sustains one beat per cycle. m_last marks
//   every BURST_LEN-th beat.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   flush      - synchronous clear of buffer, in-flight read and beat counter
//   fifo_rd_en - FIFO read request (combinational)
//   fifo_dout  - FIFO read data, valid the cycle after an accepted read
//   fifo_empty - FIFO empty flag
//   m_data     - stream data (head entry)
//   m_valid    - stream data valid
//   m_ready    - downstream accept
//   m_last     - final beat of a BURST_LEN-beat frame

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic [1:0]            occ;
  logic                  pend;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [CNT_WIDTH-1:0]  beat_cnt;

  logic                  pop;
  logic [2:0]            credit_use;
  logic [1:0]            occ_after_pop;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

  // A new read is only issued if its word is guaranteed a buffer slot when
  // it arrives next cycle: buffered + in-flight words left after this
  // cycle's pop must be below the two-entry capacity. This keeps occ+pend
  // at most 2, so the buffer can never overflow.
  always_comb begin
    pop           = m_valid && m_ready;
    credit_use    = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    fifo_rd_en    = rst_n && !flush && !fifo_empty && (credit_use < 3'd2);
    occ_after_pop = occ - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      pend     <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
      beat_cnt <= '0;
    end else if (flush) begin
      // The data slots keep stale contents; m_valid is low so they are
      // never observed.
      occ      <= 2'd0;
      pend     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      pend <= fifo_rd_en;
      occ  <= occ_after_pop + {1'b0, pend};

      if (pop) begin
        head_q   <= skid_q;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end

      // The arriving word goes to the first free slot after the pop. This
      // later assignment wins over the skid->head shift when the buffer
      // drains to empty in the same cycle.
      if (pend) begin
        if (occ_after_pop == 2'd0) begin
          head_q <= fifo_dout;
        end else begin
          skid_q <= fifo_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW        = 8;
  localparam int BL        = 16;
  localparam int MEM_WORDS = 2048;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          flush      = 1'b0;
  logic          m_ready    = 1'b0;
  logic [DW-1:0] fifo_dout  = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_last;
  logic [DW-1:0] m_data;

  // FIFO contents and stream model
  logic [DW-1:0] mem [MEM_WORDS];
  int rd_ptr    = 0;  // words the FIFO has handed out
  int avail     = 0;  // words written into the FIFO so far
  bit gap       = 0;  // forces the FIFO to look empty
  int exp_idx   = 0;  // index of the next word the stream must deliver
  int beats     = 0;  // beats delivered in the current frame
  bit last_read = 0;  // a read was accepted at the most recent edge
  int n_vec     = 0;
  int n_err     = 0;

  assign fifo_empty = (rd_ptr >= avail) || gap;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  // A word is presented when it has been read from the FIFO, has arrived
  // (not still in flight), and has not yet been consumed.
  function automatic bit exp_valid();
    return (rd_ptr - exp_idx - int'(last_read)) > 0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return mem[exp_idx];
  endfunction

  function automatic bit exp_last();
    return exp_valid() && (beats == BL - 1);
  endfunction

  // Advance one clock: FIFO responds to the request, model consumes beats.
  // Entered between edges with inputs settled; returns 1 time unit after the
  // following falling edge.
  task automatic cycle();
    bit pop;
    bit rd;
    pop = exp_valid() && m_ready && !flush;
    rd  = fifo_rd_en && !fifo_empty;
    @(posedge clk);
    #1;
    if (rd) begin
      fifo_dout = mem[rd_ptr];
      rd_ptr++;
    end
    if (!rst_n || flush) begin
      exp_idx   = rd_ptr;
      beats     = 0;
      last_read = 0;
    end else begin
      if (pop) begin
        exp_idx++;
        beats = (beats + 1) % BL;
      end
      last_read = rd;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    avail = 32;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", m_last); end
    n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 00", m_data); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL release_rd_en: got %b want 1", fifo_rd_en); end
  endtask

  task automatic test_streaming();
    int first_rd = -1, first_valid = -1, pops = 0, first_pop = -1, last_pop = -1;
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (m_valid && first_valid < 0) first_valid = c;
      n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL stream_valid: got %b want %b", m_valid, exp_valid()); end
      if (exp_valid()) begin
        n_vec++; if (m_data !== exp_data()) begin n_err++; $display("FAIL stream_data: got %h want %h", m_data, exp_data()); end
        n_vec++; if (m_last !== ((exp_data() == 8'h0F) || (exp_data() == 8'h1F))) begin
          n_err++; $display("FAIL stream_last: got %b on word %h", m_last, exp_data());
        end
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      cycle();
    end
    n_vec++; if (first_valid - first_rd != 2) begin n_err++; $display("FAIL stream_latency: got %0d want 2", first_valid - first_rd); end
    n_vec++; if (pops != 32) begin n_err++; $display("FAIL stream_count: got %0d want 32", pops); end
    n_vec++; if (last_pop - first_pop != 31) begin n_err++; $display("FAIL stream_span: got %0d want 31", last_pop - first_pop); end
  endtask

  task automatic test_backpressure();
    avail = rd_ptr + 40;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL bp_valid: got %b want %b", m_valid, exp_valid()); end
      cycle();
    end
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %b want 1", m_valid); end
      n_vec++; if (m_data !== exp_data()) begin n_err++; $display("FAIL bp_hold_data: got %h want %h", m_data, exp_data()); end
      n_vec++; if (m_last !== exp_last()) begin n_err++; $display("FAIL bp_hold_last: got %b want %b", m_last, exp_last()); end
      if (c >= 2) begin
        n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
        n_vec++; if (rd_ptr - exp_idx != 2) begin n_err++; $display("FAIL bp_buffered: got %0d want 2", rd_ptr - exp_idx); end
      end
      cycle();
    end
    m_ready = 1'b1;
    #1;
    n_vec++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL bp_resume: got %b want 1", fifo_rd_en); end
    for (int c = 0; c < 80 && exp_idx < avail; c++) begin
      #1;
      n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_gap: got %b want 1", m_valid); end
      n_vec++; if (m_data !== exp_data()) begin n_err++; $display("FAIL bp_data: got %h want %h", m_data, exp_data()); end
      n_vec++; if (m_last !== exp_last()) begin n_err++; $display("FAIL bp_last: got %b want %b", m_last, exp_last()); end
      cycle();
    end
    n_vec++; if (exp_idx != avail) begin n_err++; $display("FAIL bp_drain: got %0d want %0d", exp_idx, avail); end
  endtask

  task automatic test_random();
    int target;
    target = exp_idx + 1000;
    avail  = rd_ptr + 1000;
    for (int c = 0; c < 8000 && exp_idx < target; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      gap     = ($urandom_range(0, 3) == 0);
      #1;
      n_vec++; if ((fifo_rd_en && fifo_empty) !== 1'b0) begin n_err++; $display("FAIL rnd_rd_empty: rd_en %b empty %b", fifo_rd_en, fifo_empty); end
      n_vec++; if (rd_ptr - exp_idx > 2) begin n_err++; $display("FAIL rnd_occ: got %0d want <=2", rd_ptr - exp_idx); end
      n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL rnd_valid: got %b want %b", m_valid, exp_valid()); end
      if (exp_valid()) begin
        n_vec++; if (m_data !== exp_data()) begin n_err++; $display("FAIL rnd_data: got %h want %h", m_data, exp_data()); end
        n_vec++; if (m_last !== exp_last()) begin n_err++; $display("FAIL rnd_last: got %b want %b", m_last, exp_last()); end
      end
      cycle();
    end
    gap = 1'b0;
    n_vec++; if (exp_idx < target) begin n_err++; $display("FAIL rnd_timeout: got %0d want %0d", exp_idx, target); end
  endtask

  task automatic test_flush();
    int nxt;
    int k;
    bit hit;
    avail   = rd_ptr + 60;
    m_ready = 1'b1;
    hit     = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      #1;
      if (exp_valid() && beats == 5 && last_read) begin
        hit = 1'b1;
      end else begin
        n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL fl_pre_valid: got %b want %b", m_valid, exp_valid()); end
        cycle();
      end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL fl_setup: got no beat 5 want beat 5 reached"); end
    flush = 1'b1;
    #1;
    n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL fl_rd_en: got %b want 0", fifo_rd_en); end
    nxt = rd_ptr;
    cycle();
    flush = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", m_valid); end
    k = 0;
    for (int c = 0; c < 60 && k < 20; c++) begin
      n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL fl_post_valid: got %b want %b", m_valid, exp_valid()); end
      if (exp_valid()) begin
        n_vec++; if (m_data !== mem[nxt + k]) begin n_err++; $display("FAIL fl_data: got %h want %h", m_data, mem[nxt + k]); end
        n_vec++; if (m_last !== (k == 15)) begin n_err++; $display("FAIL fl_last: got %b want %b at beat %0d", m_last, (k == 15), k); end
        k++;
      end
      cycle();
      #1;
    end
    n_vec++; if (k != 20) begin n_err++; $display("FAIL fl_count: got %0d want 20", k); end
  endtask

  task automatic test_async_reset();
    int nxt;
    int k;
    bit hit;
    avail   = rd_ptr + 60;
    m_ready = 1'b1;
    hit     = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      #1;
      if (exp_valid() && beats == 7) begin
        hit = 1'b1;
      end else begin
        n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL ar_pre_valid: got %b want %b", m_valid, exp_valid()); end
        cycle();
      end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL ar_setup: got no beat 7 want beat 7 reached"); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", m_valid); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL ar_last: got %b want 0", m_last); end
    n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL ar_data: got %h want 00", m_data); end
    n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL ar_rd_en: got %b want 0", fifo_rd_en); end
    cycle();
    cycle();
    rst_n = 1'b1;
    nxt = rd_ptr;
    k = 0;
    for (int c = 0; c < 60 && k < 20; c++) begin
      #1;
      n_vec++; if (m_valid !== exp_valid()) begin n_err++; $display("FAIL ar_post_valid: got %b want %b", m_valid, exp_valid()); end
      if (exp_valid()) begin
        n_vec++; if (m_data !== mem[nxt + k]) begin n_err++; $display("FAIL ar_data_seq: got %h want %h", m_data, mem[nxt + k]); end
        n_vec++; if (m_last !== (k == 15)) begin n_err++; $display("FAIL ar_frame: got %b want %b at beat %0d", m_last, (k == 15), k); end
        k++;
      end
      cycle();
    end
    n_vec++; if (k != 20) begin n_err++; $display("FAIL ar_count: got %0d want 20", k); end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = (i < 32) ? DW'(i) : DW'($urandom);
    end
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
